// File: rtl/ssd_ctrl_s00_axil_regs_if.sv
// AXI4-Lite channel bundle between the PS/BFM master and the ssd_ctrl register slave.
// Signal names keep the S_AXI_* prefix so waveforms match the original port list.
interface ssd_ctrl_s00_axil_regs_if #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                        S_AXI_AWPROT;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                        S_AXI_ARPROT;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/ssd_ctrl_s00_axil_regs.sv
// AXI4-Lite register bank for ssd_ctrl: four RW config words, engine start pulse,
// sticky done status with W1C clear and a level interrupt.
module ssd_ctrl_s00_axil_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    ssd_ctrl_s00_axil_regs_if.slave       s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cfg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cfg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cfg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0] cfg3,
    output logic                          start_pulse,
    input  logic                          engine_busy,
    input  logic                          engine_done,
    output logic                          irq
);
    localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
    localparam int unsigned NBYTES = DW / 8;

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_DATA } r_state_e;

    w_state_e              w_state_q, w_state_d;
    r_state_e              r_state_q, r_state_d;

    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [2:0]            waddr_q, waddr_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic [NBYTES-1:0]     wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;

    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DW-1:0]         rdata_q, rdata_d;

    logic [DW-1:0]         regs_q [4];
    logic [DW-1:0]         regs_d [4];
    logic                  done_sticky_q, done_sticky_d;
    logic                  start_pulse_q, start_pulse_d;
    logic                  irq_q, irq_d;

    logic                  wr_en;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic [2:0]            ar_idx;
    logic [DW-1:0]         rd_mux;
    logic                  unused_inputs;

    assign aw_hs  = awready_q & s_axi.S_AXI_AWVALID;
    assign w_hs   = wready_q & s_axi.S_AXI_WVALID;
    assign ar_hs  = arready_q & s_axi.S_AXI_ARVALID;
    assign ar_idx = s_axi.S_AXI_ARADDR[4:2];

    assign unused_inputs = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                             s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

    // Write channel: AW and W are latched independently; the register update
    // happens only once both beats are held, and nothing new is accepted until B completes.
    always_comb begin
        w_state_d = w_state_q;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        wr_en     = 1'b0;

        unique case (w_state_q)
            W_IDLE: begin
                awready_d = ~aw_held_q & ~awready_q & s_axi.S_AXI_AWVALID;
                wready_d  = ~w_held_q & ~wready_q & s_axi.S_AXI_WVALID;
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    waddr_d   = s_axi.S_AXI_AWADDR[4:2];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi.S_AXI_WDATA;
                    wstrb_d  = s_axi.S_AXI_WSTRB;
                end
                if (aw_held_q && w_held_q) begin
                    wr_en     = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        regs_d        = regs_q;
        start_pulse_d = 1'b0;
        done_sticky_d = done_sticky_q;

        if (wr_en) begin
            if (!waddr_q[2]) begin
                for (int unsigned b = 0; b < NBYTES; b++) begin
                    if (wstrb_q[b]) begin
                        regs_d[waddr_q[1:0]][b*8 +: 8] = wdata_q[b*8 +: 8];
                    end
                end
            end
            if (waddr_q == 3'd0 && wstrb_q[0] && wdata_q[0] && !engine_busy) begin
                start_pulse_d = 1'b1;
            end
            if (waddr_q == 3'd4 && wdata_q[1]) begin
                done_sticky_d = 1'b0;
            end
        end
        // A completion arriving alongside a W1C clear must not be lost.
        if (engine_done) begin
            done_sticky_d = 1'b1;
        end

        irq_d = done_sticky_q & regs_q[0][1];
    end

    always_comb begin
        rd_mux = '0;
        if (!ar_idx[2]) begin
            rd_mux = regs_q[ar_idx[1:0]];
        end else if (ar_idx == 3'd4) begin
            rd_mux = {{(DW-2){1'b0}}, done_sticky_q, engine_busy};
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;

        unique case (r_state_q)
            R_IDLE: begin
                arready_d = ~arready_q & s_axi.S_AXI_ARVALID;
                if (ar_hs) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_mux;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q     <= W_IDLE;
            r_state_q     <= R_IDLE;
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            aw_held_q     <= 1'b0;
            w_held_q      <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            bvalid_q      <= 1'b0;
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            done_sticky_q <= 1'b0;
            start_pulse_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            w_state_q     <= w_state_d;
            r_state_q     <= r_state_d;
            awready_q     <= awready_d;
            wready_q      <= wready_d;
            aw_held_q     <= aw_held_d;
            w_held_q      <= w_held_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            bvalid_q      <= bvalid_d;
            arready_q     <= arready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            regs_q        <= regs_d;
            done_sticky_q <= done_sticky_d;
            start_pulse_q <= start_pulse_d;
            irq_q         <= irq_d;
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = '0;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = '0;

    assign cfg0        = regs_q[0];
    assign cfg1        = regs_q[1];
    assign cfg2        = regs_q[2];
    assign cfg3        = regs_q[3];
    assign start_pulse = start_pulse_q;
    assign irq         = irq_q;
endmodule
